// File: rtl/pc_fetch_decode.sv
// Fetch/decode front end: program counter with incrementer
// plus combinational ARM-subset instruction decoder.
module pc_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        le,
  input  logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_next,
  output logic [1:0]  am,
  output logic        rf_en,
  output logic [3:0]  alu_op,
  output logic        load,
  output logic        branch_link,
  output logic        s_bit,
  output logic        rw,
  output logic        size,
  output logic        datamem_en
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  logic is_nop;
  logic is_dp;
  logic is_ls;
  logic is_br;

  // Condition field and operand fields play no part in decode.
  logic unused_bits;
  assign unused_bits = ^{instruction[31:28],
                         instruction[19:0]};

  // Incrementer wraps naturally modulo 2^32.
  assign pc_next = pc_q + PC_STEP;
  assign pc_d    = le ? pc_next : pc_q;
  assign pc_out  = pc_q;

  // PC register; reset loads RESET_PC at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // An all-zero word is a NOP even though it
  // matches the data-processing pattern.
  assign is_nop = (instruction == 32'h0);
  assign is_dp  = ~is_nop &
                  (instruction[27:26] == 2'b00);
  assign is_ls  = (instruction[27:26] == 2'b01);
  assign is_br  = (instruction[27:25] == 3'b101);

  // Decode instruction class into the control bundle.
  always_comb begin
    am          = 2'b00;
    rf_en       = 1'b0;
    alu_op      = 4'b0000;
    load        = 1'b0;
    branch_link = 1'b0;
    s_bit       = 1'b0;
    rw          = 1'b0;
    size        = 1'b0;
    datamem_en  = 1'b0;
    unique case (1'b1)
      is_dp: begin
        alu_op = instruction[24:21];
        s_bit  = instruction[20];
        // TST/TEQ/CMP/CMN only set flags.
        rf_en  = (instruction[24:23] != 2'b10);
        am     = instruction[25] ? 2'b00 : 2'b01;
      end
      is_ls: begin
        datamem_en = 1'b1;
        load       = instruction[20];
        rf_en      = instruction[20];
        rw         = ~instruction[20];
        size       = instruction[22];
        alu_op     = instruction[23] ? 4'b0100
                                     : 4'b0010;
        am         = instruction[25] ? 2'b11 : 2'b10;
      end
      is_br: begin
        branch_link = instruction[24];
        rf_en       = instruction[24];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_decode.sv
// Self-checking bench for pc_fetch_decode: directed
// PC/decode cases plus random decode and PC tracking.
module tb_pc_fetch_decode;

  logic        clk;
  logic        rst;
  logic        le;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_next;
  logic [1:0]  am;
  logic        rf_en;
  logic [3:0]  alu_op;
  logic        load;
  logic        branch_link;
  logic        s_bit;
  logic        rw;
  logic        size;
  logic        datamem_en;

  logic [31:0] w_pc_out;
  logic [31:0] w_pc_next;
  logic [1:0]  w_am;
  logic        w_rf_en;
  logic [3:0]  w_alu_op;
  logic        w_load;
  logic        w_bl;
  logic        w_s;
  logic        w_rw;
  logic        w_size;
  logic        w_dm;

  int n_checks;
  int n_errors;

  pc_fetch_decode dut (
    .clk         (clk),
    .rst         (rst),
    .le          (le),
    .instruction (instruction),
    .pc_out      (pc_out),
    .pc_next     (pc_next),
    .am          (am),
    .rf_en       (rf_en),
    .alu_op      (alu_op),
    .load        (load),
    .branch_link (branch_link),
    .s_bit       (s_bit),
    .rw          (rw),
    .size        (size),
    .datamem_en  (datamem_en)
  );

  pc_fetch_decode #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .le          (le),
    .instruction (instruction),
    .pc_out      (w_pc_out),
    .pc_next     (w_pc_next),
    .am          (w_am),
    .rf_en       (w_rf_en),
    .alu_op      (w_alu_op),
    .load        (w_load),
    .branch_link (w_bl),
    .s_bit       (w_s),
    .rw          (w_rw),
    .size        (w_size),
    .datamem_en  (w_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [12:0] dec_vec();
    return {am, rf_en, alu_op, load, branch_link,
            s_bit, rw, size, datamem_en};
  endfunction

  // Reference decoder built from field meanings.
  function automatic logic [12:0] ref_dec(
    input logic [31:0] w);
    logic [1:0] m;
    logic [3:0] op;
    logic rf, ld, bl, s, wr, sz, dm;
    int cls;
    m = 0; op = 0; rf = 0; ld = 0; bl = 0;
    s = 0; wr = 0; sz = 0; dm = 0;
    cls = int'(w[27:25]);
    if (w == 0) begin
    end else if (cls <= 1) begin
      op = w[24:21];
      s  = w[20];
      rf = !(op >= 8 && op <= 11);
      m  = (cls == 1) ? 2'd0 : 2'd1;
    end else if (cls == 2 || cls == 3) begin
      dm = 1;
      ld = w[20];
      rf = w[20];
      wr = !w[20];
      sz = w[22];
      op = w[23] ? 4'd4 : 4'd2;
      m  = (cls == 2) ? 2'd2 : 2'd3;
    end else if (cls == 5) begin
      bl = w[24];
      rf = w[24];
    end
    return {m, rf, op, ld, bl, s, wr, sz, dm};
  endfunction

  logic [31:0] dir_w [9];
  logic [12:0] dir_e [9];
  logic [31:0] exp_pc;
  logic [31:0] r;
  logic        le_now;

  initial begin
    dir_w[0] = 32'hE211_0000;
    dir_e[0] = 13'b00_1_0000_0_0_1_0_0_0;
    dir_w[1] = 32'hE201_0000;
    dir_e[1] = 13'b00_1_0000_0_0_0_0_0_0;
    dir_w[2] = 32'hE7D1_2000;
    dir_e[2] = 13'b11_1_0100_1_0_0_0_1_1;
    dir_w[3] = 32'h1AFF_FFFD;
    dir_e[3] = 13'b0;
    dir_w[4] = 32'hEB12_3456;
    dir_e[4] = 13'b00_1_0000_0_1_0_0_0_0;
    dir_w[5] = 32'h0000_0000;
    dir_e[5] = 13'b0;
    dir_w[6] = 32'hE150_0001;
    dir_e[6] = 13'b01_0_1010_0_0_1_0_0_0;
    dir_w[7] = 32'hE581_0000;
    dir_e[7] = 13'b10_0_0100_0_0_0_1_0_1;
    dir_w[8] = 32'h0211_0000;
    dir_e[8] = 13'b00_1_0000_0_0_1_0_0_0;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    le = 1'b1;
    instruction = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc_out, 32'h0);
    check("rst_next", pc_next, 32'h4);
    check("wrap_rst_pc", w_pc_out, 32'hFFFF_FFFC);
    check("wrap_rst_next", w_pc_next, 32'h0);

    @(negedge clk);
    #2 rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("run_pc", pc_out, 32'(4 * k));
      if (k == 1)
        check("wrap_pc", w_pc_out, 32'h0);
    end

    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst", pc_out, 32'h0);
    @(posedge clk);
    #1 check("rst_vs_le", pc_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("five_steps", pc_out, 32'd20);
    @(negedge clk);
    le = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check("hold_pc", pc_out, 32'd20);
    end
    @(negedge clk);
    le = 1'b1;
    @(posedge clk);
    #1 check("resume_pc", pc_out, 32'd24);

    @(negedge clk);
    le = 1'b0;
    for (int i = 0; i < 9; i++) begin
      instruction = dir_w[i];
      #1;
      check($sformatf("dir_dec%0d", i),
            32'(dec_vec()), 32'(dir_e[i]));
    end
    check("dir_hold", pc_out, 32'd24);

    exp_pc = 32'd24;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      le_now = 1'($urandom);
      le = le_now;
      r = $urandom;
      case ($urandom_range(0, 9))
        0: instruction = 32'h0;
        1: instruction = {r[31:28], 3'b101, r[24:0]};
        default: instruction = r;
      endcase
      #1;
      check("rnd_dec", 32'(dec_vec()),
            32'(ref_dec(instruction)));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        #1;
        exp_pc = 32'h0;
        check("rnd_async", pc_out, exp_pc);
        rst = 1'b1;
      end
      @(posedge clk);
      #1;
      if (le_now) exp_pc = exp_pc + 32'd4;
      check("rnd_pc", pc_out, exp_pc);
      check("rnd_next", pc_next, exp_pc + 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
